// File: rtl/imem_loader_if.sv
// Byte-stream in / instruction-memory write port out, bundled for the loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready from the loader stalls the byte source; the memory port is never stalled.
//
// Signals:
//   in_valid/in_data/in_ready : byte source handshake (source = master)
//   mem_we/mem_addr/mem_wdata : instruction-memory write port (driven by the loader = slave)
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    // Environment side: supplies bytes, observes the memory write port.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side: consumes bytes, drives the memory write port.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses {N_hi, N_lo, N x {hi, lo}} bytes into 16-bit words and writes them sequentially.
// Latency: low byte accepted at edge k -> mem_we high for the cycle k..k+1; one word per 3 cycles at best.
// Backpressure: in_ready drops during the write cycle and outside a load; in_valid low just stalls.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : pulse that arms a new load (only from IDLE, DONE or ERR)
//   bus             : byte stream in + memory write port out (imem_loader_if.slave)
//   cpu_run         : CPU may fetch; high only after a successful load
//   busy            : load in progress
//   error           : last declared word count exceeded DEPTH
//   words_loaded    : words written in the current/last load
module imem_loader #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_run,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_W_HI,
        S_W_LO,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    state_t            state_nxt;

    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;

    logic [7:0]        cnt_hi_q;   // upper byte of the declared word count
    logic [ADDR_W-1:0] n_q;        // declared word count
    logic [ADDR_W-1:0] index_q;    // address of the word being assembled
    logic [7:0]        hi_q;       // high byte of the word being assembled

    logic              accept;
    logic [15:0]       n_full;
    logic [ADDR_W-1:0] index_inc;

    assign accept    = bus.in_valid && in_ready_q;
    // Full count as it appears on the low-byte edge; range-checked before any truncation.
    assign n_full    = {cnt_hi_q, bus.in_data};
    assign index_inc = index_q + ADDR_W'(1);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (accept) state_nxt = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (accept) begin
                    if (n_full == 16'd0)                 state_nxt = S_DONE;
                    else if (32'(n_full) > 32'(DEPTH))   state_nxt = S_ERR;
                    else                                 state_nxt = S_W_HI;
                end
            end
            S_W_HI: begin
                if (accept) state_nxt = S_W_LO;
            end
            S_W_LO: begin
                if (accept) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = (index_inc == n_q) ? S_DONE : S_W_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            cnt_hi_q     <= '0;
            n_q          <= '0;
            index_q      <= '0;
            hi_q         <= '0;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt == S_CNT_HI) || (state_nxt == S_CNT_LO) ||
                          (state_nxt == S_W_HI)   || (state_nxt == S_W_LO);
            mem_we_q   <= (state_nxt == S_WRITE);
            cpu_run    <= (state_nxt == S_DONE);
            error      <= (state_nxt == S_ERR);
            busy       <= !((state_nxt == S_IDLE) || (state_nxt == S_DONE) ||
                            (state_nxt == S_ERR));

            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) words_loaded <= '0;
                end
                S_CNT_HI: begin
                    if (accept) cnt_hi_q <= bus.in_data;
                end
                S_CNT_LO: begin
                    if (accept) begin
                        n_q     <= ADDR_W'(n_full);
                        index_q <= '0;
                    end
                end
                S_W_HI: begin
                    if (accept) hi_q <= bus.in_data;
                end
                S_W_LO: begin
                    if (accept) begin
                        mem_wdata_q <= {hi_q, bus.in_data};
                        mem_addr_q  <= index_q;
                    end
                end
                S_WRITE: begin
                    index_q      <= index_inc;
                    words_loaded <= words_loaded + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random byte streams against a queue-based model of the image format.
// Latency: n/a.
// Backpressure: the bench holds each byte until it sees in_ready, with optional random idle gaps.
module tb_imem_loader;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              cpu_run;
    logic              busy;
    logic              error;
    logic [ADDR_W-1:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0]        stream_q[$];
    logic [15:0]       words_q[$];
    logic [ADDR_W-1:0] obs_addr[$];
    logic [15:0]       obs_data[$];
    bit                prev_we = 1'b0;

    // Records every memory write; each write cycle must have in_ready low and be a single-cycle pulse.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(bus.mem_addr);
            obs_data.push_back(bus.mem_wdata);
            checks++;
            if (bus.in_ready !== 1'b0 || prev_we) begin
                $display("FAIL write_cycle: in_ready=%b prev_we=%b, required in_ready=0 prev_we=0",
                         bus.in_ready, prev_we);
            end else begin
                passed++;
            end
        end
        prev_we = (bus.mem_we === 1'b1);
    end

    // Reference model: image = 16-bit big-endian count, then words high byte first.
    // Counts above DEPTH carry no payload since the loader stops taking bytes.
    task automatic make_load(input int n);
        stream_q.delete();
        words_q.delete();
        obs_addr.delete();
        obs_data.delete();
        stream_q.push_back(8'((n >> 8) & 8'hff));
        stream_q.push_back(8'(n & 8'hff));
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                logic [15:0] w;
                w = 16'($urandom);
                words_q.push_back(w);
                stream_q.push_back(w[15:8]);
                stream_q.push_back(w[7:0]);
            end
        end
    endtask

    // Expected {cpu_run, error, busy, words_loaded} once a load of count n has settled.
    function automatic logic [ADDR_W+2:0] exp_status(input int n);
        if (n > DEPTH) return {1'b0, 1'b1, 1'b0, ADDR_W'(0)};
        return {1'b1, 1'b0, 1'b0, ADDR_W'(n)};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps, output bit ok);
        ok = 1'b1;
        for (int i = lo; i < hi && ok; i++) send_byte(stream_q[i], gaps, ok);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cpu_run === 1'b1 || error === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_run, busy, error, words_loaded} !== '0) begin
            $display("FAIL reset_state: rdy=%b we=%b addr=%h data=%h run=%b busy=%b err=%b wl=%0d, required all 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_run, busy, error, words_loaded);
        end else passed++;
    endtask

    task automatic test_basic;
        bit ok, ok2;
        int bad = 0;
        logic [7:0] img [8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'h00};
        make_load(0);
        stream_q.delete();
        foreach (img[i]) stream_q.push_back(img[i]);
        words_q = '{16'h1234, 16'hABCD, 16'hFF00};
        pulse_start();
        send_range(0, 8, 1'b0, ok);
        wait_end(ok2);
        checks++;
        if (!(ok && ok2)) $display("FAIL basic_handshake: accept=%b end=%b, required 1/1", ok, ok2);
        else passed++;
        foreach (words_q[i]) if (obs_addr[i] !== ADDR_W'(i) || obs_data[i] !== words_q[i]) bad++;
        checks++;
        if (bad != 0 || obs_addr.size() != 3) $display("FAIL basic_writes: count=%0d bad=%0d, required 3/0", obs_addr.size(), bad);
        else passed++;
        checks++;
        if ({cpu_run, error, busy, words_loaded} !== exp_status(3))
            $display("FAIL basic_status: run=%b err=%b busy=%b wl=%0d, required 1/0/0/3", cpu_run, error, busy, words_loaded);
        else passed++;
    endtask

    task automatic test_zero;
        bit ok, ok2;
        make_load(0);
        pulse_start();
        send_range(0, 2, 1'b0, ok);
        wait_end(ok2);
        checks++;
        if (!(ok && ok2) || obs_addr.size() != 0)
            $display("FAIL zero_load: accept=%b end=%b writes=%0d, required 1/1/0", ok, ok2, obs_addr.size());
        else passed++;
        checks++;
        if ({cpu_run, error, busy, words_loaded} !== exp_status(0))
            $display("FAIL zero_status: run=%b err=%b busy=%b wl=%0d, required 1/0/0/0", cpu_run, error, busy, words_loaded);
        else passed++;
    endtask

    task automatic test_err;
        bit ok, ok2;
        int bad = 0;
        make_load(257);
        pulse_start();
        send_range(0, 2, 1'b0, ok);
        wait_end(ok2);
        checks++;
        if (!(ok && ok2) || obs_addr.size() != 0 || {cpu_run, error, busy, words_loaded} !== exp_status(257))
            $display("FAIL err_status: run=%b err=%b busy=%b wl=%0d writes=%0d, required 0/1/0/0/0",
                     cpu_run, error, busy, words_loaded, obs_addr.size());
        else passed++;
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1)
            $display("FAIL err_clear: err=%b busy=%b, required 0/1", error, busy);
        else passed++;
        make_load(1);
        send_range(0, stream_q.size(), 1'b1, ok);
        wait_end(ok2);
        foreach (words_q[i]) if (obs_addr[i] !== ADDR_W'(i) || obs_data[i] !== words_q[i]) bad++;
        checks++;
        if (!(ok && ok2) || bad != 0 || obs_addr.size() != 1 || {cpu_run, error, busy, words_loaded} !== exp_status(1))
            $display("FAIL err_recover: run=%b err=%b wl=%0d writes=%0d bad=%0d, required 1/0/1/1/0",
                     cpu_run, error, words_loaded, obs_addr.size(), bad);
        else passed++;
    endtask

    task automatic test_random(input int n, input bit gaps);
        bit ok, ok2;
        int bad = 0;
        make_load(n);
        pulse_start();
        send_range(0, stream_q.size(), gaps, ok);
        wait_end(ok2);
        foreach (words_q[i]) if (obs_addr[i] !== ADDR_W'(i) || obs_data[i] !== words_q[i]) bad++;
        checks++;
        if (!(ok && ok2) || bad != 0 || obs_addr.size() != n)
            $display("FAIL random_writes n=%0d: accept=%b end=%b writes=%0d bad=%0d, required 1/1/%0d/0",
                     n, ok, ok2, obs_addr.size(), bad, n);
        else passed++;
        checks++;
        if ({cpu_run, error, busy, words_loaded} !== exp_status(n))
            $display("FAIL random_status n=%0d: run=%b err=%b busy=%b wl=%0d, required 1/0/0/%0d",
                     n, cpu_run, error, busy, words_loaded, n);
        else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        make_load(5);
        pulse_start();
        // count + two words + high byte of word 2 leaves the loader waiting for that word's low byte
        send_range(0, 7, 1'b1, ok);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_run, busy, error, words_loaded} !== '0)
            $display("FAIL reset_mid: accept=%b rdy=%b we=%b addr=%h data=%h run=%b busy=%b err=%b wl=%0d, required 1 then all 0",
                     ok, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_run, busy, error, words_loaded);
        else passed++;
        checks++;
        if (obs_addr.size() != 2) $display("FAIL reset_mid_writes: writes=%0d, required 2", obs_addr.size());
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        test_random(2, 1'b1);
    endtask

    task automatic test_start_ignored;
        bit ok, ok2;
        int bad = 0;
        // loader is in DONE here; start must drop cpu_run on the edge that samples it
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (cpu_run !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1)
            $display("FAIL start_from_done: run=%b busy=%b rdy=%b, required 0/1/1", cpu_run, busy, bus.in_ready);
        else passed++;
        make_load(4);
        send_range(0, 4, 1'b0, ok);
        checks++;
        if (!ok || bus.mem_we !== 1'b1 || bus.mem_addr !== '0 || bus.mem_wdata !== words_q[0])
            $display("FAIL write_latency: accept=%b we=%b addr=%h data=%h, required 1/1/0/%h",
                     ok, bus.mem_we, bus.mem_addr, bus.mem_wdata, words_q[0]);
        else passed++;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        send_range(4, stream_q.size(), 1'b1, ok);
        wait_end(ok2);
        foreach (words_q[i]) if (obs_addr[i] !== ADDR_W'(i) || obs_data[i] !== words_q[i]) bad++;
        checks++;
        if (!(ok && ok2) || bad != 0 || obs_addr.size() != 4 || {cpu_run, error, busy, words_loaded} !== exp_status(4))
            $display("FAIL start_ignored: run=%b err=%b wl=%0d writes=%0d bad=%0d, required 1/0/4/4/0",
                     cpu_run, error, words_loaded, obs_addr.size(), bad);
        else passed++;
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #7;
        test_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        test_reset();
        test_basic();
        test_zero();
        test_err();
        for (int k = 0; k < 3; k++) test_random($urandom_range(1, 24), 1'b1);
        test_random(DEPTH, 1'b0);
        test_reset_mid();
        test_start_ignored();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
